// File: rtl/imm_narrow.sv
`default_nettype none
// ============================================================================
//  Module   : imm_narrow
//  Purpose  : Narrows 16-bit two's-complement words to OUT_W-bit signed
//             immediates (inverse of the 5-to-16 sign extension). Each result
//             carries a lossless-fit flag; out-of-range words are either
//             truncated or saturated as selected per word. One registered
//             stage with valid/ready on both sides and a saturating counter
//             of non-fitting words.
//  Revision : 1.0  initial release
// ============================================================================
module imm_narrow #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 5,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   input  logic              sat_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_fit,
   output logic [CNT_W-1:0]  ovf_count,
   input  logic              clr_count
);

   // Saturation limits for an OUT_W-bit signed value.
   localparam logic [OUT_W-1:0] c_max_pos = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] c_min_neg = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic                     r_out_valid;
   logic [OUT_W-1:0]         r_out_data;
   logic                     r_out_fit;
   logic [CNT_W-1:0]         r_ovf_count;

   logic [IN_W-OUT_W:0]      w_upper;
   logic                     w_fit;
   logic [OUT_W-1:0]         w_narrow;
   logic                     w_in_xfer;
   logic                     w_out_xfer;

   // The word fits when every bit from the new sign position upward is a
   // copy of the sign bit, i.e. sign extension would reproduce it exactly.
   assign w_upper    = in_data[IN_W-1:OUT_W-1];
   assign w_fit      = (&w_upper) | ~(|w_upper);

   assign in_ready   = !r_out_valid || out_ready;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_out_valid && out_ready;

   // Select the narrowed value: low bits unless saturating an overflow.
   always_comb begin
      w_narrow = in_data[OUT_W-1:0];
      if (!w_fit && sat_mode) begin
         w_narrow = in_data[IN_W-1] ? c_min_neg : c_max_pos;
      end
   end

   // Output register: load on input transfer, drain on output transfer,
   // otherwise hold the current result stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_fit   <= 1'b0;
      end else if (w_in_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_narrow;
         r_out_fit   <= w_fit;
      end else if (w_out_xfer) begin
         r_out_valid <= 1'b0;
      end
   end

   // Saturating count of accepted non-fitting words; clear has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf_count <= '0;
      end else if (clr_count) begin
         r_ovf_count <= '0;
      end else if (w_in_xfer && !w_fit && (r_ovf_count != c_cnt_max)) begin
         r_ovf_count <= r_ovf_count + 1'b1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_fit   = r_out_fit;
   assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_narrow.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_narrow
//  Purpose  : Self-checking bench for imm_narrow. Directed scenarios plus a
//             random valid/ready stream, all checked against a queue-based
//             reference model computed with integer arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_narrow;

   localparam int IN_W  = 16;
   localparam int OUT_W = 5;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_data;
   logic              sat_mode;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_fit;
   logic [CNT_W-1:0]  ovf_count;
   logic              clr_count;

   int total = 0;
   int bad   = 0;

   // Reference state: results waiting downstream and expected counter value.
   logic [OUT_W:0] q[$];
   int             m_cnt;

   imm_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sat_mode  (sat_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_fit   (out_fit),
      .ovf_count (ovf_count),
      .clr_count (clr_count)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference narrowing: returns {fit, data}.
   function automatic logic [OUT_W:0] ref_narrow(input logic [IN_W-1:0] d, input logic s);
      int v  = int'($signed(d));
      int lo = -(1 << (OUT_W-1));
      int hi = (1 << (OUT_W-1)) - 1;
      int o;
      logic f;
      f = (v >= lo) && (v <= hi);
      if (f || !s) o = v;
      else         o = (v < 0) ? lo : hi;
      return {f, o[OUT_W-1:0]};
   endfunction

   // One clock: drive inputs, check pre-edge outputs against the model,
   // advance, then update the model with the transfers that happened.
   task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic s,
                        input logic r, input logic c);
      logic ix, ox;
      logic [OUT_W:0] e;
      in_valid = v; in_data = d; sat_mode = s; out_ready = r; clr_count = c;
      #1;
      chk("in_ready", in_ready, (q.size() == 0) || r);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("out_data", out_data, q[0][OUT_W-1:0]);
         chk("out_fit", out_fit, q[0][OUT_W]);
      end
      chk("ovf_count", ovf_count, m_cnt);
      ix = v && ((q.size() == 0) || r);
      ox = (q.size() != 0) && r;
      e  = ref_narrow(d, s);
      @(posedge clk); #1;
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(e);
      if (c) m_cnt = 0;
      else if (ix && !e[OUT_W] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      m_cnt = 0;
   endtask

   function automatic logic [IN_W-1:0] rand_word();
      int sv;
      if ($urandom_range(0, 3) == 0) return IN_W'($urandom);
      sv = int'($urandom_range(0, 40)) - 20;
      return sv[IN_W-1:0];
   endfunction

   initial begin
      int accepted;
      int cycles;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; sat_mode = 1'b0;
      out_ready = 1'b0; clr_count = 1'b0;
      q.delete(); m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Reset state
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_fit", out_fit, 0);
      chk("rst_ovf_count", ovf_count, 0);
      chk("rst_in_ready", in_ready, 1);

      // 0x000F fits
      cycle(1, 16'h000F, 0, 1, 0);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 5'b01111);
      chk("t1_fit", out_fit, 1);
      chk("t1_cnt", ovf_count, 0);

      // -16 fits, +16 saturates
      cycle(1, 16'hFFF0, 1, 1, 0);
      chk("m16_data", out_data, 5'b10000);
      chk("m16_fit", out_fit, 1);
      cycle(1, 16'h0010, 1, 1, 0);
      chk("p16_data", out_data, 5'b01111);
      chk("p16_fit", out_fit, 0);
      chk("p16_cnt", ovf_count, 1);
      cycle(0, 16'h0000, 0, 1, 0);

      // 0x8000 truncated then saturated
      do_reset();
      cycle(1, 16'h8000, 0, 1, 0);
      chk("n8k_trunc_data", out_data, 5'b00000);
      chk("n8k_trunc_fit", out_fit, 0);
      cycle(1, 16'h8000, 1, 1, 0);
      chk("n8k_sat_data", out_data, 5'b10000);
      chk("n8k_sat_fit", out_fit, 0);
      chk("n8k_cnt", ovf_count, 2);

      // Stall: hold 0x0003 for three cycles while 0x0007 waits
      cycle(0, 16'h0000, 0, 1, 0);
      cycle(1, 16'h0003, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 16'h0007; sat_mode = 1'b1; out_ready = 1'b0;
         #1;
         chk("stall_in_ready", in_ready, 0);
         chk("stall_data", out_data, 5'b00011);
         cycle(1, 16'h0007, 1, 0, 0);
      end
      cycle(1, 16'h0007, 0, 1, 0);
      chk("unstall_data", out_data, 5'b00111);
      chk("unstall_valid", out_valid, 1);
      cycle(0, 16'h0000, 0, 1, 0);

      // Counter saturation then clear against an overflowing transfer
      do_reset();
      for (int i = 0; i < (1 << CNT_W) + 5; i++) cycle(1, 16'h4000, 0, 1, 0);
      chk("cnt_sat", ovf_count, 16'hFFFF);
      cycle(1, 16'h4000, 0, 1, 1);
      chk("cnt_clr", ovf_count, 0);
      cycle(0, 16'h0000, 0, 1, 0);

      // Reset during a stall drops the held word
      cycle(1, 16'h0100, 0, 0, 0);
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_cnt", ovf_count, 1);
      out_ready = 1'b0;
      do_reset();
      #1;
      chk("stall_rst_valid", out_valid, 0);
      chk("stall_rst_cnt", ovf_count, 0);
      chk("stall_rst_in_ready", in_ready, 1);

      // Random stream of 100 accepted words with random back-pressure
      accepted = 0;
      cycles = 0;
      while (accepted < 100 && cycles < 2000) begin
         logic v, r;
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         if (v && ((q.size() == 0) || r)) accepted++;
         cycle(v, rand_word(), 1'($urandom), r, ($urandom_range(0, 49) == 0));
         cycles++;
      end
      chk("stream_accepted", accepted, 100);
      // Drain remaining word
      cycle(0, 16'h0000, 0, 1, 0);
      cycle(0, 16'h0000, 0, 1, 0);
      chk("drain_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imm_narrow.md
Name: imm_narrow

Overview:
- Inverse of the datapath's 5-to-16-bit immediate sign extension: accepts 16-bit two's-complement words and produces 5-bit signed immediates for the instruction encoder/loader path.
- Each result carries a fit flag, set when the narrowing is lossless.
- Single-stage registered pipeline with valid/ready handshakes on both sides and a saturating overflow counter.

Parameters:
- IN_W, 16, input word width.
- OUT_W, 5, output immediate width; must satisfy 2 <= OUT_W < IN_W.
- CNT_W, 16, overflow counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  IN_W  signed source value.
- sat_mode  input  1  sampled with in_data: 1 = saturate on overflow, 0 = truncate.
- out_valid  output  1  out_data/out_fit valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_W  narrowed immediate.
- out_fit  output  1  1 = in_data in [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- ovf_count  output  CNT_W  number of accepted words with fit = 0.
- clr_count  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset, applied on a clk edge with rst = 1:
  - out_valid = 0, out_data = 0, out_fit = 0, ovf_count = 0.
  - Any held result is discarded.
  - in_ready = 1 from the first cycle after reset.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - Full throughput: one word per cycle with out_ready held high.
- Latency: result is registered and appears on out_valid/out_data exactly 1 cycle after the input transfer.
- Output register holds its value while out_valid && !out_ready:
  - out_data and out_fit stable, no new input accepted.
  - out_valid clears on an output transfer with no simultaneous input transfer.
- Fit rule: fit = 1 iff in_data[IN_W-1:OUT_W-1] are all equal. With the defaults, bits [15:4] all 0 or all 1, i.e. range -16..15.
- Data rule:
  - fit = 1: out_data = in_data[OUT_W-1:0].
  - fit = 0, sat_mode = 0: out_data = in_data[OUT_W-1:0] (plain truncation).
  - fit = 0, sat_mode = 1: in_data[IN_W-1] = 0 gives max positive (01111); in_data[IN_W-1] = 1 gives min negative (10000).
  - sat_mode is captured with the word; changes while a result is held have no effect on it.
- Counter:
  - Increments by 1 on each input transfer with fit = 0.
  - Saturates at all-ones; no wrap.
  - clr_count = 1 sets it to 0 on the next edge. Clear wins over a simultaneous increment.
  - Counter update is independent of out_ready stall.
- Simultaneous events: output transfer and input transfer in the same cycle load the new result; out_valid stays 1.
- Reset during a stall drops the held word. No output transfer is reported for it, and ovf_count returns to 0.
- No X propagation: out_data is don't-care only while out_valid = 0, but must still be driven from a register.

Test Plan:
- Reset, then in_data = 16'h000F, sat_mode = 0, out_ready = 1 -> next cycle out_valid = 1, out_data = 5'b01111, out_fit = 1, ovf_count = 0.
- in_data = 16'hFFF0 (-16), then 16'h0010 (+16) with sat_mode = 1:
  - -16 -> out_data = 10000, fit = 1.
  - +16 -> out_data = 01111, fit = 0, ovf_count = 1.
- in_data = 16'h8000 with sat_mode = 0 and then sat_mode = 1:
  - sat_mode = 0 -> out_data = 00000, fit = 0.
  - sat_mode = 1 -> out_data = 10000, fit = 0.
  - ovf_count = 2.
- Stall: out_ready = 0 for 3 cycles with in_valid = 1 (word 16'h0003 held):
  - in_ready = 0 and out_data = 00011 stable for all 3 cycles.
  - out_ready = 1 -> next queued word appears 1 cycle later; no word lost or duplicated across a 100-word random stream checked against a model.
- Counter: force 2^CNT_W + 5 overflowing words -> ovf_count stays at 16'hFFFF. Then clr_count = 1 in the same cycle as an overflowing transfer -> ovf_count = 0.
- Assert rst while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, ovf_count = 0, in_ready = 1.
